flash_ram_loader: RTL
=====================

// Module: flash_ram_loader
// PURPOSE
//  Boot-time copy engine: moves NUM_REGIONS flash regions (BIOS, FM-BIOS, MegaROM, ...) into SDRAM.
//  Generalises the fixed flash/RAM map constants into a parametrised region table.
//  Sits between the flash byte-stream reader and the SDRAM arbiter write port.
//  Holds the rest of the cartridge off (BUSY) until all regions are resident.
// PARAMETERS
//  NUM_REGIONS  3    number of table entries (1..8)
//  ADDR_W       24   byte address width for both flash and RAM
//  REGION_TABLE  -   CONFIG_LOADER::region_t [NUM_REGIONS]; default NEXTOR, FM-BIOS, MEGAROM entries
//  AUTO_START   1    1: start one cycle after reset release; 0: wait for START
// PORTS
//  CLK               in   1         system clock
//  RESET_n           in   1         asynchronous active-low reset
//  START             in   1         one-cycle pulse; ignored while BUSY
//  BUSY              out  1         copy in progress
//  DONE              out  1         high after last region; cleared by next START
//  CUR_REGION        out  3         index of region being copied
//  FLASH_REQ         out  1         stream request; held until FLASH_ACK
//  FLASH_ACK         in   1         reader accepted FLASH_ADDR/FLASH_LEN
//  FLASH_ADDR        out  ADDR_W    first flash byte of region
//  FLASH_LEN         out  ADDR_W    byte count of region
//  FLASH_DOUT        in   8         streamed byte
//  FLASH_DOUT_VALID  in   1         byte valid
//  FLASH_DOUT_READY  out  1         loader accepts byte (transfer = VALID & READY)
//  RAM_REQ           out  1         word write request; held until RAM_ACK
//  RAM_ACK           in   1         write accepted
//  RAM_ADDR          out  ADDR_W-1  word address (byte address >> 1)
//  RAM_DIN           out  16        write data, even byte in [7:0]
//  RAM_BE            out  2         byte enables, [0] = even byte
//  CHECKSUM          out  16        per-region byte sum (only with LOADER_CHECKSUM_EN)
// BEHAVIOUR
//  - Interface: one clock CLK; reset is asynchronous and active-low (RESET_n).
//  - Reset: all outputs 0, state IDLE, CUR_REGION 0, holding register cleared. Reset mid-copy aborts
//    immediately, with no final flush.
//  - FSM: IDLE -> SETUP -> REQ -> STREAM -> FLUSH -> NEXT -> (SETUP | DONE).
//    SETUP: load region; size 0 -> NEXT directly (no FLASH_REQ).
//    REQ: FLASH_REQ=1 until FLASH_ACK; then STREAM.
//    STREAM: READY=1 only when no RAM write is pending. Each byte goes to the holding word at
//    ram_ptr[0] and sets BE. Issue RAM write when the odd byte fills or the last byte of the region
//    arrives. ram_ptr++, remaining--.
//    FLUSH: wait RAM_ACK of final write. NEXT: idx++; idx==NUM_REGIONS -> DONE (BUSY=0, DONE=1).
//  - A region starting at an odd RAM address emits a first write with BE=2'b10.
//  - An odd ending emits BE=2'b01. Disabled lanes of RAM_DIN are driven 0.
//  - RAM_REQ/ADDR/DIN/BE stay stable while RAM_REQ=1 and RAM_ACK=0. READY stays 0 during that time,
//    so no byte is lost.
//  - FLASH_DOUT_VALID outside STREAM is ignored. Bytes beyond FLASH_LEN are never accepted.
//  - Latency: the first RAM_REQ comes no later than 1 cycle after the completing byte transfer.
//    Sustained rate is 1 byte/cycle when RAM_ACK is immediate.
//  - START in DONE restarts from region 0. Address pointers wrap modulo 2^ADDR_W.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: CHECKSUM is a 16-bit wrapping sum of the current region's bytes.
//    It clears in SETUP and is valid from NEXT until the next SETUP.
//  Undefined: CHECKSUM tied to 0, no adder logic.
// STRUCTURE
//  Package CONFIG_LOADER holds:
//  - region_t {flash_addr, ram_addr, size}
//  - state_t enum
//  - the default table built from the CONFIG flash/RAM constants
//  Sub-module loader_word_packer: byte->16-bit packing, BE generation and the write-pending
//  handshake.
// TESTING
//  1 Region {0x100000->0x700000, 4}, bytes 11 22 33 44 -> writes 0x380000 D=2211 BE=11; 0x380001 D=4433 BE=11; DONE.
//  2 Region {.., ram 0x700001, 3}, bytes AA BB CC -> 0x380000 D=AA00 BE=10; 0x380001 D=CCBB BE=11.
//  3 Table {size 0, size 2} -> no FLASH_REQ for region 0; CUR_REGION passes 0->1; one write.
//  4 RAM_ACK held low 5 cycles mid-stream -> READY=0 throughout; all bytes written in order.
//  5 RESET_n low during STREAM -> all outputs 0 same cycle; after START, copy restarts at region 0.
//  6 LOADER_CHECKSUM_EN, bytes 01 02 03 FF -> CHECKSUM=0x0105 at NEXT. Undefined: CHECKSUM=0.

Source files
------------

// File: rtl/flash_ram_loader_pkg.sv
// Shared types and constants for the flash-to-SDRAM boot copy engine.
// Holds the region descriptor, the loader state encoding and the default
// region table built from the cartridge flash/RAM map constants.
package flash_ram_loader_pkg;

  // Width of every field in a region descriptor (byte addresses and sizes)
  localparam int REGION_ADDR_W       = 24;
  localparam int DEFAULT_NUM_REGIONS = 3;

  // One copy job: source flash byte address, destination RAM byte address, length in bytes
  typedef struct packed {
    logic [REGION_ADDR_W-1:0] flash_addr;
    logic [REGION_ADDR_W-1:0] ram_addr;
    logic [REGION_ADDR_W-1:0] size;
  } region_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_REQ    = 3'd2,
    ST_STREAM = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Cartridge flash/RAM map: where each image lives in flash and where it runs from in SDRAM
  localparam logic [REGION_ADDR_W-1:0] NEXTOR_FLASH_ADDR  = 24'h10_0000;
  localparam logic [REGION_ADDR_W-1:0] NEXTOR_RAM_ADDR    = 24'h00_0000;
  localparam logic [REGION_ADDR_W-1:0] NEXTOR_SIZE        = 24'h02_0000;
  localparam logic [REGION_ADDR_W-1:0] FMBIOS_FLASH_ADDR  = 24'h12_0000;
  localparam logic [REGION_ADDR_W-1:0] FMBIOS_RAM_ADDR    = 24'h02_0000;
  localparam logic [REGION_ADDR_W-1:0] FMBIOS_SIZE        = 24'h00_4000;
  localparam logic [REGION_ADDR_W-1:0] MEGAROM_FLASH_ADDR = 24'h14_0000;
  localparam logic [REGION_ADDR_W-1:0] MEGAROM_RAM_ADDR   = 24'h10_0000;
  localparam logic [REGION_ADDR_W-1:0] MEGAROM_SIZE       = 24'h08_0000;

  // Builds a region descriptor; usable in parameter/localparam expressions
  function automatic region_t makeRegion(
    input logic [REGION_ADDR_W-1:0] flashAddr,
    input logic [REGION_ADDR_W-1:0] ramAddr,
    input logic [REGION_ADDR_W-1:0] byteCount
  );
    region_t r;
    r.flash_addr = flashAddr;
    r.ram_addr   = ramAddr;
    r.size       = byteCount;
    return r;
  endfunction

  // Index 0 is copied first: NEXTOR, then FM-BIOS, then MegaROM
  localparam region_t [DEFAULT_NUM_REGIONS-1:0] DEFAULT_TABLE = {
    makeRegion(MEGAROM_FLASH_ADDR, MEGAROM_RAM_ADDR, MEGAROM_SIZE),
    makeRegion(FMBIOS_FLASH_ADDR,  FMBIOS_RAM_ADDR,  FMBIOS_SIZE),
    makeRegion(NEXTOR_FLASH_ADDR,  NEXTOR_RAM_ADDR,  NEXTOR_SIZE)
  };

endpackage

// File: rtl/flash_ram_loader_word_packer.sv
// Packs the flash byte stream into 16-bit SDRAM word writes.
// Each byte lands in the lane picked by the RAM byte address bit 0; a write is
// raised when the odd lane fills or the region's last byte arrives. The write
// request, address, data and byte enables are held until the arbiter acks, and
// no new byte is taken while an unacknowledged write is outstanding.
module flash_ram_loader_word_packer
  import flash_ram_loader_pkg::*;
#(
  parameter int ADDR_W = REGION_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              byte_xfer_i,
  input  logic [7:0]        byte_i,
  input  logic              lane_i,
  input  logic              last_i,
  input  logic [ADDR_W-2:0] word_addr_i,
  output logic              can_accept_o,
  output logic              pending_o,
  output logic              ram_req_o,
  input  logic              ram_ack_i,
  output logic [ADDR_W-2:0] ram_addr_o,
  output logic [15:0]       ram_din_o,
  output logic [1:0]        ram_be_o
);

  logic [15:0]       word_q,    word_d;
  logic [1:0]        be_q,      be_d;
  logic [ADDR_W-2:0] addr_q,    addr_d;
  logic              pending_q, pending_d;

  // A byte may enter in the same cycle the outstanding write is acknowledged
  assign can_accept_o = ~pending_q | ram_ack_i;
  assign pending_o    = pending_q;
  assign ram_req_o    = pending_q;
  assign ram_addr_o   = addr_q;
  assign ram_din_o    = word_q;
  assign ram_be_o     = be_q;

  // Next holding word: clear on ack so unused lanes read 0, then merge any incoming byte
  always_comb begin
    word_d    = word_q;
    be_d      = be_q;
    addr_d    = addr_q;
    pending_d = pending_q;
    if (pending_q && ram_ack_i) begin
      pending_d = 1'b0;
      word_d    = 16'h0000;
      be_d      = 2'b00;
    end
    if (byte_xfer_i) begin
      if (lane_i) begin
        word_d[15:8] = byte_i;
        be_d[1]      = 1'b1;
      end else begin
        word_d[7:0]  = byte_i;
        be_d[0]      = 1'b1;
      end
      addr_d = word_addr_i;
      if (lane_i || last_i) begin
        pending_d = 1'b1;
      end
    end
  end

  // Holding register and write-pending flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q    <= 16'h0000;
      be_q      <= 2'b00;
      addr_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/flash_ram_loader.sv
// Boot-time copy engine: walks a table of flash regions and streams each one
// into SDRAM through the word packer, holding BUSY until every region is
// resident. Optional feature macro: LOADER_CHECKSUM_EN adds a 16-bit wrapping
// byte sum of the current region on checksum_o (tied to 0 when undefined).
module flash_ram_loader
  import flash_ram_loader_pkg::*;
#(
  parameter int                          NUM_REGIONS  = DEFAULT_NUM_REGIONS,
  parameter int                          ADDR_W       = REGION_ADDR_W,
  parameter region_t [NUM_REGIONS-1:0]   REGION_TABLE = DEFAULT_TABLE,
  parameter bit                          AUTO_START   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        cur_region_o,
  output logic              flash_req_o,
  input  logic              flash_ack_i,
  output logic [ADDR_W-1:0] flash_addr_o,
  output logic [ADDR_W-1:0] flash_len_o,
  input  logic [7:0]        flash_dout_i,
  input  logic              flash_dout_valid_i,
  output logic              flash_dout_ready_o,
  output logic              ram_req_o,
  input  logic              ram_ack_i,
  output logic [ADDR_W-2:0] ram_addr_o,
  output logic [15:0]       ram_din_o,
  output logic [1:0]        ram_be_o,
  output logic [15:0]       checksum_o
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_REGIONS - 1);

  state_t            state_q, state_d;
  logic [2:0]        idx_q;
  logic              autoStart_q;
  logic [ADDR_W-1:0] flashAddr_q;
  logic [ADDR_W-1:0] flashLen_q;
  logic [ADDR_W-1:0] ramPtr_q;
  logic [ADDR_W-1:0] remaining_q;

  region_t           curEntry;
  logic [ADDR_W-1:0] entrySize;
  logic              streamEn;
  logic              canAccept;
  logic              pending;
  logic              byteXfer;
  logic              lastByte;
  logic              startCopy;

  // Look up the table entry for the region currently selected
  always_comb begin
    curEntry = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (idx_q == 3'(i)) begin
        curEntry = REGION_TABLE[i];
      end
    end
  end

  assign entrySize          = ADDR_W'(curEntry.size);
  assign flash_dout_ready_o = streamEn & canAccept;
  assign byteXfer           = flash_dout_ready_o & flash_dout_valid_i;
  assign lastByte           = (remaining_q == ADDR_W'(1));
  assign startCopy          = start_i | autoStart_q;
  assign cur_region_o       = idx_q;
  assign flash_addr_o       = flashAddr_q;
  assign flash_len_o        = flashLen_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: sequence each region through request, stream and final flush
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (startCopy)                state_d = ST_SETUP;
      ST_SETUP:  if (entrySize == '0)          state_d = ST_NEXT;
                 else                          state_d = ST_REQ;
      ST_REQ:    if (flash_ack_i)              state_d = ST_STREAM;
      ST_STREAM: if (byteXfer && lastByte)     state_d = ST_FLUSH;
      ST_FLUSH:  if (!pending || ram_ack_i)    state_d = ST_NEXT;
      ST_NEXT:   if (idx_q == LAST_IDX)        state_d = ST_DONE;
                 else                          state_d = ST_SETUP;
      ST_DONE:   if (start_i)                  state_d = ST_SETUP;
      default:                                 state_d = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the current state
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    flash_req_o = 1'b0;
    streamEn    = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_DONE:   done_o = 1'b1;
      ST_REQ: begin
        busy_o      = 1'b1;
        flash_req_o = 1'b1;
      end
      ST_STREAM: begin
        busy_o   = 1'b1;
        streamEn = 1'b1;
      end
      default:   busy_o = 1'b1;
    endcase
  end

  // Region pointers: load on SETUP, advance per accepted byte, step index on NEXT
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= 3'd0;
      autoStart_q <= AUTO_START;
      flashAddr_q <= '0;
      flashLen_q  <= '0;
      ramPtr_q    <= '0;
      remaining_q <= '0;
    end else begin
      if ((state_q == ST_IDLE || state_q == ST_DONE) && state_d == ST_SETUP) begin
        idx_q       <= 3'd0;
        autoStart_q <= 1'b0;
      end
      if (state_q == ST_SETUP) begin
        flashAddr_q <= ADDR_W'(curEntry.flash_addr);
        flashLen_q  <= entrySize;
        ramPtr_q    <= ADDR_W'(curEntry.ram_addr);
        remaining_q <= entrySize;
      end
      if (byteXfer) begin
        ramPtr_q    <= ramPtr_q + ADDR_W'(1);
        remaining_q <= remaining_q - ADDR_W'(1);
      end
      if (state_q == ST_NEXT && idx_q != LAST_IDX) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  flash_ram_loader_word_packer #(
    .ADDR_W (ADDR_W)
  ) u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .byte_xfer_i  (byteXfer),
    .byte_i       (flash_dout_i),
    .lane_i       (ramPtr_q[0]),
    .last_i       (lastByte),
    .word_addr_i  (ramPtr_q[ADDR_W-1:1]),
    .can_accept_o (canAccept),
    .pending_o    (pending),
    .ram_req_o    (ram_req_o),
    .ram_ack_i    (ram_ack_i),
    .ram_addr_o   (ram_addr_o),
    .ram_din_o    (ram_din_o),
    .ram_be_o     (ram_be_o)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  // Running byte sum of the region being copied, restarted for every region
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      checksum_q <= 16'h0000;
    end else if (state_q == ST_SETUP) begin
      checksum_q <= 16'h0000;
    end else if (byteXfer) begin
      checksum_q <= checksum_q + {8'h00, flash_dout_i};
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 16'h0000;
`endif

endmodule
